// File: rtl/sh2_bus_bridge.sv
// sh2_bus_bridge: SH7604 external-bus slave that turns each selected bus cycle
// into one request on a variable-latency memory port. WAIT_N holds the CPU
// until the memory acknowledges or the timeout expires. A minimum stall of
// WS_MIN+1 bus phases is always enforced.
// Optional feature macro: SH_BRIDGE_COMM_EN adds eight 16-bit communication
// registers at 0x4020..0x402E. These are served locally, with no memory request,
// and are exported on COMM_O.
//
// state | meaning
// IDLE  | waiting for a selected bus cycle (or one deferred from DONE)
// REQ   | memory request outstanding, timeout counter running
// HOLD  | data settled, waiting for the minimum stall to elapse
// DONE  | WAIT_N released for one bus phase, DI held stable
`timescale 1ns/1ps
module sh2_bus_bridge #(
  parameter int unsigned WS_MIN  = 1,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE_R,
  input  logic [26:0]  A,
  input  logic [31:0]  DO,
  input  logic         BS_N,
  input  logic         CS0_N,
  input  logic         RD_N,
  input  logic [3:0]   WE_N,
  output logic [31:0]  DI,
  output logic         WAIT_N,
  output logic [26:0]  MEM_A,
  output logic [31:0]  MEM_D,
  output logic [3:0]   MEM_BE,
  output logic         MEM_WR,
  output logic         MEM_REQ,
  input  logic [31:0]  MEM_Q,
  input  logic         MEM_ACK,
  output logic         BUS_ERR,
  input  logic         ERR_CLR
`ifdef SH_BRIDGE_COMM_EN
  ,
  output logic [127:0] COMM_O
`endif
);

  localparam logic [2:0] WS_LD  = 3'(WS_MIN);
  localparam logic [7:0] TMO_LD = 8'(TMO_CYC);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt;
  logic [7:0]  tmo_cnt;
  logic        pend;
  logic        sel;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [26:0] src_a;
  logic [31:0] src_d;
  logic [3:0]  src_be;
  logic        src_wr;
  logic        start;
  logic        ack_take;
  logic        tmo_hit;
  logic        wait_done;
  logic        comm_hit;

  // Decode the current strobe. A cycle deferred from DONE replays from the
  // already-latched MEM_* registers.
  always_comb begin
    sel    = CE_R & ~BS_N & ~CS0_N;
    bus_wr = RD_N & ~(&WE_N);
    bus_be = bus_wr ? ~WE_N : 4'hF;
    if (pend) begin
      src_a  = MEM_A;
      src_d  = MEM_D;
      src_be = MEM_BE;
      src_wr = MEM_WR;
    end else begin
      src_a  = A;
      src_d  = DO;
      src_be = bus_be;
      src_wr = bus_wr;
    end
  end

`ifdef SH_BRIDGE_COMM_EN
  logic [15:0] comm [8];
  assign comm_hit = (src_a[26:4] == 23'h000402);
`else
  assign comm_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the per-state events used by the datapath.
  // An ack takes priority over a timeout that expires in the same CLK.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_take  = 1'b0;
    tmo_hit   = 1'b0;
    wait_done = 1'b0;
    case (state)
      IDLE: begin
        start = CE_R & (pend | (~BS_N & ~CS0_N));
        if (start) state_nxt = comm_hit ? HOLD : REQ;
      end
      REQ: begin
        ack_take = MEM_ACK;
        tmo_hit  = ~MEM_ACK & CE_R & (tmo_cnt == 8'd1);
        if (ack_take | tmo_hit) state_nxt = HOLD;
      end
      HOLD: begin
        wait_done = CE_R & (wait_cnt == 3'd0);
        if (wait_done) state_nxt = DONE;
      end
      DONE: if (CE_R) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, counters, read data, wait and error flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DI       <= '0;
      WAIT_N   <= 1'b1;
      MEM_A    <= '0;
      MEM_D    <= '0;
      MEM_BE   <= '0;
      MEM_WR   <= 1'b0;
      MEM_REQ  <= 1'b0;
      BUS_ERR  <= 1'b0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      if (tmo_hit)      BUS_ERR <= 1'b1;
      else if (ERR_CLR) BUS_ERR <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            MEM_A    <= src_a;
            MEM_D    <= src_d;
            MEM_BE   <= src_be;
            MEM_WR   <= src_wr;
            MEM_REQ  <= ~comm_hit;
            WAIT_N   <= 1'b0;
            wait_cnt <= WS_LD;
            tmo_cnt  <= TMO_LD;
            pend     <= 1'b0;
`ifdef SH_BRIDGE_COMM_EN
            if (comm_hit & ~src_wr) DI <= {16'h0000, comm[src_a[3:1]]};
`endif
          end
        end
        REQ: begin
          // The minimum stall counts from the start of the cycle, not from the ack.
          if (CE_R && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
          if (ack_take) begin
            MEM_REQ <= 1'b0;
            if (!MEM_WR) DI <= MEM_Q;
          end else if (tmo_hit) begin
            MEM_REQ <= 1'b0;
            DI      <= 32'hFFFF_FFFF;
          end else if (CE_R) begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        HOLD: begin
          if (CE_R) begin
            if (wait_cnt == 3'd0) WAIT_N   <= 1'b1;
            else                  wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          // A cycle started during DONE is parked here and issued from IDLE.
          if (sel) begin
            MEM_A  <= A;
            MEM_D  <= DO;
            MEM_BE <= bus_be;
            MEM_WR <= bus_wr;
            pend   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SH_BRIDGE_COMM_EN
  // Communication register writes, byte-lane merged into the low half-word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) comm[i] <= '0;
    end else if (start & comm_hit & src_wr) begin
      if (src_be[1]) comm[src_a[3:1]][15:8] <= src_d[15:8];
      if (src_be[0]) comm[src_a[3:1]][7:0]  <= src_d[7:0];
    end
  end

  // Flatten the register file onto the export port.
  always_comb begin
    COMM_O = '0;
    for (int i = 0; i < 8; i++) COMM_O[16*i +: 16] = comm[i];
  end
`endif

endmodule

// File: tb/tb_sh2_bus_bridge.sv
// Testbench for sh2_bus_bridge: directed checks followed by randomized
// bus cycles. Expected values come from a cycle-count model of the bridge.
`timescale 1ns/1ps
module tb_sh2_bus_bridge;

  localparam int WS  = 3;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst, ce_r, bs_n, cs0_n, rd_n, mem_ack, err_clr;
  logic [26:0]  a;
  logic [31:0]  cpu_do, mem_q;
  logic [3:0]   we_n;
  logic [31:0]  di, mem_d;
  logic         wait_n, mem_wr, mem_req, bus_err;
  logic [26:0]  mem_a;
  logic [3:0]   mem_be;
`ifdef SH_BRIDGE_COMM_EN
  logic [127:0] comm_o;
`endif

  int          tests;
  int          fails;
  int          ce_div;
  int          div;
  logic [31:0] di_model;
  logic        err_model;
  logic [3:0]  we_tab [8];

  sh2_bus_bridge #(.WS_MIN(WS), .TMO_CYC(TMO)) dut (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .A(a), .DO(cpu_do), .BS_N(bs_n),
    .CS0_N(cs0_n), .RD_N(rd_n), .WE_N(we_n), .DI(di), .WAIT_N(wait_n),
    .MEM_A(mem_a), .MEM_D(mem_d), .MEM_BE(mem_be), .MEM_WR(mem_wr),
    .MEM_REQ(mem_req), .MEM_Q(mem_q), .MEM_ACK(mem_ack), .BUS_ERR(bus_err),
    .ERR_CLR(err_clr)
`ifdef SH_BRIDGE_COMM_EN
    , .COMM_O(comm_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CLK; CE_R is high on every ce_div-th edge. Sampling happens 1ns after the edge.
  task automatic tick();
    ce_r = (div == ce_div - 1);
    @(posedge clk);
    #1;
    div = (div == ce_div - 1) ? 0 : div + 1;
  endtask

  task automatic idle_ce();
    bit c;
    do begin
      c = (div == ce_div - 1);
      tick();
    end while (!c);
  endtask

  task automatic bus_idle();
    bs_n   = 1'b1;
    cs0_n  = 1'b1;
    rd_n   = 1'b1;
    we_n   = 4'hF;
    a      = 27'($urandom);
    cpu_do = $urandom;
  endtask

  // One bus cycle to the memory port. lat = CLK edge after accept on which
  // MEM_ACK is pulsed (0 = never). b2b = strobe lands in DONE of the previous cycle.
  task automatic access(input logic [26:0] ai, input logic [31:0] dv, input logic [3:0] wi,
                        input int lat, input logic [31:0] q, input bit b2b, input bit clr_hold);
    bit         ewr, done_f, tmo_f, fin, ce_now;
    logic [3:0] ebe;
    int         k, ce_idx, first_after, exp_stall;
    ewr = (wi != 4'hF);
    ebe = ewr ? ~wi : 4'hF;
    while (div != ce_div - 1) tick();
    bs_n = 1'b0; cs0_n = 1'b0; a = ai; cpu_do = dv; we_n = wi; rd_n = ewr;
    tick();
    bus_idle();
    if (b2b) begin
      chk("b2b_deferred", {wait_n, mem_req}, 2'b10);
      while (div != ce_div - 1) tick();
      tick();
    end
    chk("accept_wait_n", wait_n, 1'b0);
    chk("accept_req", mem_req, 1'b1);
    chk("accept_addr", mem_a, ai);
    chk("accept_data", mem_d, dv);
    chk("accept_be_wr", {mem_be, mem_wr}, {ebe, ewr});
    err_clr = clr_hold;
    k = 0; ce_idx = 0; first_after = -1; done_f = 0; tmo_f = 0; fin = 0; ce_now = 0;
    while (!fin) begin
      k++;
      mem_ack = (k == lat);
      mem_q   = (k == lat) ? q : $urandom;
      ce_now  = (div == ce_div - 1);
      tick();
      mem_ack = 1'b0;
      if (ce_now) ce_idx++;
      if (!done_f) begin
        if (k == lat) done_f = 1;
        else if (ce_now && ce_idx == TMO) begin done_f = 1; tmo_f = 1; end
        if (done_f) begin
          err_clr = 1'b0;
          chk("req_drop", mem_req, 1'b0);
        end else begin
          chk("req_hold", {mem_req, mem_wr, mem_be, mem_a}, {1'b1, ewr, ebe, ai});
          chk("req_hold_data", mem_d, dv);
        end
      end else if (ce_now && first_after < 0) begin
        first_after = ce_idx;
      end
      if (wait_n === 1'b1) fin = 1;
      else if (k >= 400) begin
        chk("release_bound", wait_n, 1'b1);
        fin = 1;
      end
    end
    err_clr = 1'b0;
    exp_stall = (first_after > WS + 1) ? first_after : WS + 1;
    chk("stall_phases", {done_f, ce_now, first_after > 0, 32'(ce_idx)},
        {1'b1, 1'b1, 1'b1, 32'(exp_stall)});
    if (tmo_f) begin
      di_model  = 32'hFFFF_FFFF;
      err_model = 1'b1;
    end else begin
      if (!ewr)    di_model  = q;
      if (clr_hold) err_model = 1'b0;
    end
    chk("di", di, di_model);
    chk("bus_err", bus_err, err_model);
    chk("req_after", mem_req, 1'b0);
  endtask

`ifdef SH_BRIDGE_COMM_EN
  task automatic comm_access(input logic [26:0] ai, input logic [31:0] dv, input logic [3:0] wi);
    bit ce_now, saw_req;
    int ce_idx, k;
    idle_ce();
    while (div != ce_div - 1) tick();
    bs_n = 1'b0; cs0_n = 1'b0; a = ai; cpu_do = dv; we_n = wi; rd_n = (wi != 4'hF);
    tick();
    bus_idle();
    chk("comm_wait_low", wait_n, 1'b0);
    saw_req = mem_req; ce_idx = 0; k = 0;
    while (wait_n !== 1'b1 && k < 200) begin
      ce_now = (div == ce_div - 1);
      tick();
      k++;
      if (ce_now) ce_idx++;
      saw_req |= mem_req;
    end
    chk("comm_no_req", saw_req, 1'b0);
    chk("comm_stall", 32'(ce_idx), 32'(WS + 1));
  endtask
`endif

  initial begin
    bit         b2b, clr;
    int         lat;
    logic [26:0] ra;
    tests = 0; fails = 0; ce_div = 4; div = 0;
    di_model = '0; err_model = 1'b0;
    we_tab = '{4'hF, 4'h0, 4'h3, 4'hC, 4'hE, 4'hD, 4'hB, 4'h7};
    rst = 1'b1; ce_r = 1'b0; mem_ack = 1'b0; mem_q = '0; err_clr = 1'b0;
    bus_idle();
    tick(); tick();
    chk("reset_di_d", {di, mem_d}, 64'h0);
    chk("reset_ctrl", {wait_n, mem_a, mem_be, mem_wr, mem_req, bus_err},
        {1'b1, 27'h0, 4'h0, 3'b000});
    rst = 1'b0;
    tick();

    // Read at 0x100, ack three CLKs after the request.
    access(27'h000_0100, 32'h0, 4'hF, 3, 32'h1234_5678, 0, 0);
    // Upper two byte-lane write.
    idle_ce();
    access(27'h000_2468, 32'h55AA_0000, 4'b0011, 2, 32'hCAFE_F00D, 0, 0);
    // Ack on the first CLK of REQ with CE_R every CLK: stall is exactly WS+1.
    idle_ce(); ce_div = 1; div = 0;
    access(27'h011_0000, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 0, 0);
    // No ack: timeout, then an ERR_CLR pulse.
    idle_ce(); ce_div = 2; div = 0;
    access(27'h7FF_FFFC, 32'h0, 4'hF, 0, 32'h0, 0, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0; err_model = 1'b0;
    chk("err_clr", bus_err, 1'b0);
    // ERR_CLR held across a timeout: the set wins.
    idle_ce();
    access(27'h000_0040, 32'h0, 4'hF, 0, 32'h0, 0, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; err_model = 1'b0;
    // Ack in the same CLK as timeout expiry: the ack wins.
    idle_ce(); ce_div = 1; div = 0;
    access(27'h000_0080, 32'h0, 4'hF, TMO, 32'h7777_1111, 0, 0);
    // Back-to-back strobe landing in DONE.
    access(27'h000_0200, 32'h0, 4'hF, 2, 32'h2222_3333, 1, 0);

    // BS_N with CS0_N high: no action.
    idle_ce(); ce_div = 3; div = 0;
    while (div != ce_div - 1) tick();
    bs_n = 1'b0; cs0_n = 1'b1; a = 27'h0100; rd_n = 1'b0;
    tick();
    bus_idle();
    chk("cs_off_idle", {wait_n, mem_req}, 2'b10);
    repeat (4) tick();
    chk("cs_off_later", {wait_n, mem_req}, 2'b10);

    // MEM_ACK while idle is ignored.
    mem_ack = 1'b1; mem_q = 32'hA5A5_5A5A; tick(); mem_ack = 1'b0;
    chk("idle_ack_di", di, di_model);
    chk("idle_ack_req", mem_req, 1'b0);

    // Reset while in REQ, then a late ack.
    while (div != ce_div - 1) tick();
    bs_n = 1'b0; cs0_n = 1'b0; a = 27'h0123; rd_n = 1'b0; we_n = 4'hF;
    tick();
    bus_idle();
    chk("rst_pre_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_di_d", {di, mem_d}, 64'h0);
    chk("rst_mid_ctrl", {wait_n, mem_a, mem_be, mem_wr, mem_req, bus_err},
        {1'b1, 27'h0, 4'h0, 3'b000});
    #1 rst = 1'b0;
    di_model = '0; err_model = 1'b0;
    tick();
    mem_ack = 1'b1; mem_q = 32'hDEAD_BEEF; tick(); mem_ack = 1'b0;
    tick();
    chk("late_ack_di", di, 32'h0);
    chk("late_ack_ctrl", {wait_n, mem_req}, 2'b10);

`ifdef SH_BRIDGE_COMM_EN
    ce_div = 2; div = 0;
    comm_access(27'h000_4020, 32'h0000_534D, 4'b1100);
    chk("comm_o_reg0", comm_o[15:0], 16'h534D);
    comm_access(27'h000_4020, 32'h0, 4'hF);
    di_model = 32'h0000_534D;
    chk("comm_read", di, di_model);
    comm_access(27'h000_402E, 32'h0000_A5C3, 4'b1110);
    chk("comm_o_reg7", comm_o[127:112], 16'h00C3);
    chk("comm_o_reg0_kept", comm_o[15:0], 16'h534D);
`else
    idle_ce();
    access(27'h000_4020, 32'h0000_534D, 4'b1100, 2, 32'h0, 0, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      b2b = ($urandom_range(0, 3) == 0);
      if (!b2b) begin
        idle_ce();
        ce_div = $urandom_range(1, 4);
        div = 0;
      end
      ra = 27'($urandom);
      if (ra[26:4] == 23'h000402) ra[26] = 1'b1;
      lat = $urandom_range(0, 14);
      clr = ($urandom_range(0, 5) == 0);
      access(ra, $urandom, we_tab[$urandom_range(0, 7)], lat, $urandom, b2b, clr);
    end

    idle_ce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
